// File: rtl/keypad_scanner.sv
// keypad_scanner: ROWSxCOLS matrix-keypad scanner with tick-based debounce, a key-code
// FIFO on a valid/ready port and a 2-flop enter synchroniser. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 1,
    parameter int DEBOUNCE     = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ROWS-1:0]              row,
    output logic [COLS-1:0]              col,
    output logic [$clog2(ROWS*COLS)-1:0] key_code,
    output logic                         key_valid,
    input  logic                         key_ready,
    output logic                         key_held,
    output logic                         overflow,
    input  logic                         enter,
    output logic                         enter_sync
);
    localparam int CW = $clog2(ROWS*COLS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int NW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [COLS-1:0] col_q, col_d, col_rot_s;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [ROWS-1:0] cand_row_q, cand_row_d;
    logic [CW-1:0]   cand_code_q, cand_code_d, code_s;
    logic            push_q, push_d, key_held_q, key_held_d;
    logic [CW-1:0]   mem_q [FIFO_DEPTH];
    logic [CW-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [CW-1:0]   key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d, overflow_q, overflow_d;
    logic            enter_meta_q, enter_sync_q;
    logic            tick_s, cand_seen_s, pop_s, full_s, do_push_s;
    int              row_idx_s, col_idx_s;
`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
    int            rep_limit_s;
`endif

    assign tick_s      = (div_q == DW'(SCAN_DIV - 1));
    assign div_d       = tick_s ? '0 : div_q + DW'(1);
    assign col_rot_s   = {col_q[COLS-2:0], col_q[COLS-1]};
    assign cand_seen_s = |(row & cand_row_q);

    // Linear code of the sampled key: row index * COLS + parked column index
    always_comb begin
        row_idx_s = 0;
        col_idx_s = 0;
        for (int i = 0; i < ROWS; i++) row_idx_s = row[i] ? i : row_idx_s;
        for (int j = 0; j < COLS; j++) col_idx_s = col_q[j] ? j : col_idx_s;
        code_s = CW'(row_idx_s * COLS + col_idx_s);
    end

    // Scan/debounce FSM next state; only ticks advance it
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        cand_row_d  = cand_row_q;
        cand_code_d = cand_code_q;
        push_d      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_limit_s = rep_first_q ? REPEAT_DELAY : REPEAT_RATE;
`endif
        if (tick_s) begin
            case (state_q)
                S_IDLE: begin
                    if ($onehot(row)) begin
                        cand_row_d  = row;
                        cand_code_d = code_s;
                        if (DEBOUNCE == 1) begin
                            state_d = S_HELD;
                            push_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_DEBOUNCE;
                            cnt_d   = NW'(1);
                        end
                    end else begin
                        col_d = col_rot_s;
                    end
                end
                S_DEBOUNCE: begin
                    if (row == cand_row_q) begin
                        if (cnt_q + NW'(1) == NW'(DEBOUNCE)) begin
                            state_d = S_HELD;
                            push_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + NW'(1);
                        end
                    end else begin
                        state_d = S_IDLE;
                        col_d   = col_rot_s;
                        cnt_d   = '0;
                    end
                end
                S_HELD: begin
                    if (!cand_seen_s) begin
                        if (DEBOUNCE == 1) begin
                            state_d = S_IDLE;
                            col_d   = col_rot_s;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_RELEASE;
                            cnt_d   = NW'(1);
                        end
                    end else begin
                        state_d = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt_q + RW'(1) == RW'(rep_limit_s)) begin
                            push_d      = 1'b1;
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RW'(1);
                        end
`endif
                    end
                end
                S_RELEASE: begin
                    if (cand_seen_s) begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q + NW'(1) == NW'(DEBOUNCE)) begin
                        state_d = S_IDLE;
                        col_d   = col_rot_s;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    col_d   = COLS'(1);
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
`ifdef KEYPAD_REPEAT_EN
        // Any entry to or exit from HELD restarts the repeat delay
        if (!(state_q == S_HELD && state_d == S_HELD)) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else begin
            rep_first_d = rep_first_d;
        end
`endif
        key_held_d = (state_d == S_HELD) || (state_d == S_RELEASE);
    end

    // FIFO bookkeeping; the registered head is rebuilt from the next-state pointers
    always_comb begin
        pop_s       = key_valid_q & key_ready;
        full_s      = (count_q == (AW+1)'(FIFO_DEPTH));
        do_push_s   = push_q & (~full_s | pop_s);
        overflow_d  = push_q & full_s & ~pop_s;
        wr_ptr_d    = wr_ptr_q + AW'(do_push_s);
        rd_ptr_d    = rd_ptr_q + AW'(pop_s);
        count_d     = count_q + (AW+1)'(do_push_s) - (AW+1)'(pop_s);
        key_valid_d = (count_d != '0);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = (do_push_s && wr_ptr_q == AW'(i)) ? cand_code_q : mem_q[i];
        end
        if (count_d == '0) begin
            key_code_d = key_code_q;
        end else if (count_q == '0 || (count_q == (AW+1)'(1) && pop_s)) begin
            key_code_d = cand_code_q;
        end else begin
            key_code_d = mem_q[rd_ptr_d];
        end
    end

    // Control, FIFO and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            col_q        <= COLS'(1);
            cnt_q        <= '0;
            cand_row_q   <= '0;
            cand_code_q  <= '0;
            push_q       <= 1'b0;
            key_held_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            enter_meta_q <= 1'b0;
            enter_sync_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q    <= '0;
            rep_first_q  <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            cand_row_q   <= cand_row_d;
            cand_code_q  <= cand_code_d;
            push_q       <= push_d;
            key_held_q   <= key_held_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            overflow_q   <= overflow_d;
            enter_meta_q <= enter;
            enter_sync_q <= enter_meta_q;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q    <= rep_cnt_d;
            rep_first_q  <= rep_first_d;
`endif
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign col        = col_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;
    assign overflow   = overflow_q;
    assign enter_sync = enter_sync_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (4x4, SCAN_DIV=1, DEBOUNCE=3, FIFO_DEPTH=4):
// a key-matrix model drives row from col; a vector table plus hand-written corner sequences.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_s;
    logic [3:0]  col_s;
    logic [3:0]  key_code_s;
    logic        key_valid_s, key_ready_s = 1'b0, key_held_s, overflow_s;
    logic        enter_s = 1'b0, enter_sync_s;
    logic [15:0] key_mask = 16'h0000;
    int          total = 0;
    int          bad = 0;
    int          ovf_pulses = 0;

    typedef struct {
        logic [15:0] keys;
        logic        ready;
        int          steps;
        logic [3:0]  col;
        logic        valid;
        logic [3:0]  code;
        logic        held;
    } vec_t;
    vec_t vecs [14];

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(1), .DEBOUNCE(3), .FIFO_DEPTH(4),
        .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row_s), .col(col_s),
        .key_code(key_code_s), .key_valid(key_valid_s), .key_ready(key_ready_s),
        .key_held(key_held_s), .overflow(overflow_s),
        .enter(enter_s), .enter_sync(enter_sync_s)
    );

    always #5 clk = ~clk;

    // Key matrix: key r*4+c closes row r while column c is strobed
    always_comb begin
        row_s = 4'b0000;
        for (int r = 0; r < 4; r++) row_s[r] = |(key_mask[r*4 +: 4] & col_s);
    end

    always @(negedge clk) begin
        if (rst_n && overflow_s) ovf_pulses <= ovf_pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_held(input logic lvl, input string nm);
        int n = 0;
        while (key_held_s !== lvl && n < 40) begin
            step();
            n++;
        end
        check(nm, {31'd0, key_held_s}, {31'd0, lvl});
    endtask

    task automatic press(input int code);
        key_mask[code] = 1'b1;
        wait_held(1'b1, $sformatf("press_%0d_held", code));
    endtask

    task automatic release_key(input int code);
        key_mask[code] = 1'b0;
        wait_held(1'b0, $sformatf("release_%0d", code));
    endtask

    task automatic drain4(input logic [15:0] codes, input string nm);
        key_ready_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_valid%0d", nm, i), {31'd0, key_valid_s}, 32'd1);
            check($sformatf("%s_code%0d", nm, i), {28'd0, key_code_s}, {28'd0, codes[15-4*i -: 4]});
            step();
        end
        check($sformatf("%s_empty", nm), {31'd0, key_valid_s}, 32'd0);
        key_ready_s = 1'b0;
    endtask

    initial begin
        //          keys      rdy   n  col    vld   code   held
        vecs[0]  = '{16'h0000, 1'b0, 1, 4'h2, 1'b0, 4'h0, 1'b0};
        vecs[1]  = '{16'h0000, 1'b0, 1, 4'h4, 1'b0, 4'h0, 1'b0};
        vecs[2]  = '{16'h0000, 1'b0, 1, 4'h8, 1'b0, 4'h0, 1'b0};
        vecs[3]  = '{16'h0000, 1'b0, 1, 4'h1, 1'b0, 4'h0, 1'b0};
        vecs[4]  = '{16'h0000, 1'b0, 1, 4'h2, 1'b0, 4'h0, 1'b0};
        vecs[5]  = '{16'h0200, 1'b0, 1, 4'h2, 1'b0, 4'h0, 1'b0};
        vecs[6]  = '{16'h0200, 1'b0, 2, 4'h2, 1'b0, 4'h0, 1'b1};
        vecs[7]  = '{16'h0200, 1'b0, 1, 4'h2, 1'b1, 4'h9, 1'b1};
        vecs[8]  = '{16'h0200, 1'b0, 5, 4'h2, 1'b1, 4'h9, 1'b1};
        vecs[9]  = '{16'h0000, 1'b0, 2, 4'h2, 1'b1, 4'h9, 1'b1};
        vecs[10] = '{16'h0000, 1'b0, 1, 4'h4, 1'b1, 4'h9, 1'b0};
        vecs[11] = '{16'h0000, 1'b0, 1, 4'h8, 1'b1, 4'h9, 1'b0};
        vecs[12] = '{16'h0000, 1'b1, 1, 4'h1, 1'b0, 4'h9, 1'b0};
        vecs[13] = '{16'h0000, 1'b1, 1, 4'h2, 1'b0, 4'h9, 1'b0};

        repeat (3) step();
        check("rst_col", {28'd0, col_s}, 32'd1);
        check("rst_valid", {31'd0, key_valid_s}, 32'd0);
        check("rst_code", {28'd0, key_code_s}, 32'd0);
        check("rst_held", {31'd0, key_held_s}, 32'd0);
        check("rst_overflow", {31'd0, overflow_s}, 32'd0);
        check("rst_enter_sync", {31'd0, enter_sync_s}, 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            key_mask    = vecs[v].keys;
            key_ready_s = vecs[v].ready;
            for (int s = 0; s < vecs[v].steps; s++) step();
            check($sformatf("v%0d_col", v), {28'd0, col_s}, {28'd0, vecs[v].col});
            check($sformatf("v%0d_valid", v), {31'd0, key_valid_s}, {31'd0, vecs[v].valid});
            check($sformatf("v%0d_code", v), {28'd0, key_code_s}, {28'd0, vecs[v].code});
            check($sformatf("v%0d_held", v), {31'd0, key_held_s}, {31'd0, vecs[v].held});
            check($sformatf("v%0d_overflow", v), {31'd0, overflow_s}, 32'd0);
        end
        key_ready_s = 1'b0;

        // Bounce: 2 ticks present, 1 absent, then stable on key 13 (row 3, col 1)
        key_mask[13] = 1'b1;
        step(); step();
        check("bounce_burst_held", {31'd0, key_held_s}, 32'd0);
        check("bounce_burst_col", {28'd0, col_s}, 32'd2);
        key_mask[13] = 1'b0;
        step();
        check("bounce_abort_col", {28'd0, col_s}, 32'd4);
        key_mask[13] = 1'b1;
        repeat (4) step();
        check("bounce_redetect_col", {28'd0, col_s}, 32'd2);
        check("bounce_redetect_held", {31'd0, key_held_s}, 32'd0);
        step(); step();
        check("bounce_accept_held", {31'd0, key_held_s}, 32'd1);
        check("bounce_accept_valid", {31'd0, key_valid_s}, 32'd0);
        step();
        check("bounce_valid", {31'd0, key_valid_s}, 32'd1);
        check("bounce_code", {28'd0, key_code_s}, 32'd13);
        key_mask[13] = 1'b0;
        repeat (3) step();
        check("bounce_release_held", {31'd0, key_held_s}, 32'd0);
        check("bounce_release_col", {28'd0, col_s}, 32'd4);
        key_ready_s = 1'b1;
        step();
        key_ready_s = 1'b0;
        check("bounce_single_entry", {31'd0, key_valid_s}, 32'd0);

        // Overflow: five presses with the consumer stalled
        press(0);  release_key(0);
        press(6);  release_key(6);
        press(11); release_key(11);
        press(12); release_key(12);
        check("ovf_none_yet", ovf_pulses, 32'd0);
        press(7);  release_key(7);
        check("ovf_one_pulse", ovf_pulses, 32'd1);
        drain4(16'h06BC, "ovf_drain");

        // Full FIFO, pop on the same cycle as the push lands
        press(1); release_key(1);
        press(2); release_key(2);
        press(3); release_key(3);
        press(4); release_key(4);
        press(5);
        key_ready_s = 1'b1;
        step();
        key_ready_s = 1'b0;
        check("simul_no_ovf", ovf_pulses, 32'd1);
        check("simul_head", {28'd0, key_code_s}, 32'd2);
        release_key(5);
        drain4(16'h2345, "simul_drain");

        // Reset while a key is held and the FIFO is non-empty
        press(10);
        step();
        check("midhold_valid", {31'd0, key_valid_s}, 32'd1);
        rst_n = 1'b0;
        step();
        check("midhold_rst_col", {28'd0, col_s}, 32'd1);
        check("midhold_rst_valid", {31'd0, key_valid_s}, 32'd0);
        check("midhold_rst_held", {31'd0, key_held_s}, 32'd0);
        check("midhold_rst_code", {28'd0, key_code_s}, 32'd0);
        key_mask = 16'h0000;
        rst_n = 1'b1;
        step();
        check("midhold_resume_col", {28'd0, col_s}, 32'd2);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat: pushes at accept, +5, +7, +9, +11 each surface one edge later
        key_ready_s = 1'b1;
        press(5);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("repeat_valid_t%0d", k), {31'd0, key_valid_s},
                  {31'd0, (k == 1 || k == 6 || k == 8 || k == 10 || k == 12)});
        end
        check("repeat_code", {28'd0, key_code_s}, 32'd5);
        release_key(5);
        key_ready_s = 1'b0;
`endif

        // Enter synchroniser: two-edge latency
        enter_s = 1'b1;
        step();
        check("enter_lat1", {31'd0, enter_sync_s}, 32'd0);
        step();
        check("enter_lat2", {31'd0, enter_sync_s}, 32'd1);
        enter_s = 1'b0;
        step(); step();
        check("enter_fall", {31'd0, enter_sync_s}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
